icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the IF stage and instruction ROM.
- Consumes the IF request, address and jump indication.
- Produces the combinational hit, data-valid (ready) and instruction word. The flow controller uses these to stall the PC/IF-ID path and to validate ID's instruction.
- On a miss, refills one full line from ROM word by word, then returns the requested word.

---
 rtl/icache_dm_if.sv | 42 ++++
 rtl/icache_dm.sv | 147 ++++++++++++++
 tb/tb_icache_dm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and ROM-side signal bundle for the direct-mapped I-cache.
// The cache takes the slave view; the fetch unit / ROM side takes master.
interface icache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_Icache_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_jump_Icache_i;
    logic              Icache_hit_o;
    logic              Icache_ready_o;
    logic [31:0]       Icache_inst_o;
    logic              Icache_req_rom_o;
    logic [ADDR_W-1:0] Icache_addr_rom_o;
    logic              rom_ready_i;
    logic [31:0]       rom_data_i;

    modport slave (
        input  if_req_Icache_i,
        input  if_addr_i,
        input  if_jump_Icache_i,
        output Icache_hit_o,
        output Icache_ready_o,
        output Icache_inst_o,
        output Icache_req_rom_o,
        output Icache_addr_rom_o,
        input  rom_ready_i,
        input  rom_data_i
    );

    modport master (
        output if_req_Icache_i,
        output if_addr_i,
        output if_jump_Icache_i,
        input  Icache_hit_o,
        input  Icache_ready_o,
        input  Icache_inst_o,
        input  Icache_req_rom_o,
        input  Icache_addr_rom_o,
        output rom_ready_i,
        output rom_data_i
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Hits answer in the same cycle; misses refill a whole line then respond.
module icache_dm #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input logic        clk,
    input logic        rst,
    icache_dm_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LO    = OFF_W + 2;
    localparam int TAG_W = ADDR_W - LO - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  word_q, word_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [NUM_LINES-1:0] valid_q;

    logic [31:0]      data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [NUM_LINES];

    logic [OFF_W-1:0] req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             tag_match;
    logic             unused_addr_lo;

    logic              beat;
    logic              fill_done;
    logic              hit;
    logic              ready;
    logic [31:0]       inst;
    logic              req_rom;
    logic [ADDR_W-1:0] addr_rom;

    assign req_word  = bus.if_addr_i[LO-1:2];
    assign req_idx   = bus.if_addr_i[LO+IDX_W-1:LO];
    assign req_tag   = bus.if_addr_i[ADDR_W-1:LO+IDX_W];
    assign fill_idx  = base_q[LO+IDX_W-1:LO];
    assign fill_tag  = base_q[ADDR_W-1:LO+IDX_W];
    assign tag_match = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_lo = ^bus.if_addr_i[1:0];

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        beat      = 1'b0;
        fill_done = 1'b0;
        hit       = 1'b0;
        ready     = 1'b0;
        inst      = '0;
        req_rom   = 1'b0;
        addr_rom  = '0;
        unique case (state_q)
            IDLE: begin
                hit = bus.if_req_Icache_i && tag_match;
                if (hit) begin
                    ready = 1'b1;
                    inst  = data_q[req_idx][req_word];
                end else if (bus.if_req_Icache_i && !bus.if_jump_Icache_i) begin
                    base_d  = {bus.if_addr_i[ADDR_W-1:LO], {LO{1'b0}}};
                    word_d  = req_word;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                req_rom  = 1'b1;
                addr_rom = base_q + (ADDR_W'(cnt_q) << 2);
                if (bus.if_jump_Icache_i) drop_d = 1'b1;
                if (bus.rom_ready_i) begin
                    beat  = 1'b1;
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST) begin
                        fill_done = 1'b1;
                        drop_d    = 1'b0;
                        // An abandoned fetch still leaves a valid line behind
                        state_d   = (drop_q || bus.if_jump_Icache_i) ? IDLE : RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!bus.if_jump_Icache_i) begin
                    ready = 1'b1;
                    inst  = data_q[fill_idx][word_q];
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            hit      = 1'b0;
            ready    = 1'b0;
            inst     = '0;
            req_rom  = 1'b0;
            addr_rom = '0;
        end
    end

    assign bus.Icache_hit_o      = hit;
    assign bus.Icache_ready_o    = ready;
    assign bus.Icache_inst_o     = inst;
    assign bus.Icache_req_rom_o  = req_rom;
    assign bus.Icache_addr_rom_o = addr_rom;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            if (fill_done) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; valid bits qualify their contents
    always_ff @(posedge clk) begin
        if (!rst && beat) data_q[fill_idx][cnt_q] <= bus.rom_data_i;
        if (!rst && fill_done) tag_q[fill_idx] <= fill_tag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, corner
// sequences and random fetches against an abstract cache-content model.
module tb_icache_dm;
    logic clk;
    logic rst;

    icache_dm_if #(.ADDR_W(32)) bus ();

    icache_dm #(
        .NUM_LINES (16),
        .LINE_WORDS(4),
        .ADDR_W    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [31:0] rom_mem [1024];

    bit          mv [16];
    logic [23:0] mt [16];

    bit          r_hit0;
    int          r_ready_cnt;
    logic [31:0] r_inst;
    int          r_lat;
    int          r_beats;
    bit          r_addr_bad;
    bit          r_to;
    bit          r_rst_done;
    bit          r_zero_ok;

    typedef struct {
        logic [31:0] addr;
        int          gap;
        int          jmp;
        int          rsa;
        bit          hit0;
        int          rdy;
        int          lat;
        logic [31:0] inst;
        int          beats;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int gap,
                         input int jump_at, input int rst_at);
        int wt;
        bit abort;
        logic [31:0] base;
        base = a & ~32'hF;
        r_hit0 = 0; r_ready_cnt = 0; r_inst = '0; r_lat = 0;
        r_beats = 0; r_addr_bad = 0; r_to = 0;
        r_rst_done = 0; r_zero_ok = 0;
        wt = 0; abort = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.if_req_Icache_i  = !abort;
            bus.if_addr_i        = a;
            bus.if_jump_Icache_i = 1'b0;
            bus.rom_ready_i      = 1'b0;
            bus.rom_data_i       = '0;
            rst = 1'b0;
            if (r_rst_done) begin
                bus.if_req_Icache_i = 1'b0;
                #1;
                r_zero_ok = !bus.Icache_hit_o && !bus.Icache_ready_o &&
                            bus.Icache_inst_o == 0 && !bus.Icache_req_rom_o &&
                            bus.Icache_addr_rom_o == 0;
                return;
            end
            if (!abort && jump_at >= 0 && r_beats == jump_at) begin
                bus.if_jump_Icache_i = 1'b1;
                abort = 1;
            end
            if (!abort && rst_at >= 0 && r_beats == rst_at) begin
                rst = 1'b1;
                abort = 1;
            end
            #1;
            if (bus.Icache_req_rom_o && !rst) begin
                if (wt >= gap) begin
                    if (bus.Icache_addr_rom_o !== base + 32'(r_beats * 4))
                        r_addr_bad = 1;
                    bus.rom_ready_i = 1'b1;
                    bus.rom_data_i  = rom_mem[bus.Icache_addr_rom_o[11:2]];
                    r_beats++;
                    wt = 0;
                end else begin
                    wt++;
                end
            end
            #1;
            if (cyc == 0) r_hit0 = bus.Icache_hit_o;
            if (bus.Icache_ready_o) begin
                r_ready_cnt++;
                r_inst = bus.Icache_inst_o;
                r_lat  = cyc + 1;
            end
            if (rst) r_rst_done = 1;
            if (r_ready_cnt > 0 && !abort) return;
            if (abort && !rst && !bus.Icache_req_rom_o) return;
        end
        r_to = 1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int idx;
        fetch(v.addr, v.gap, v.jmp, v.rsa);
        chk({tag, " timeout"}, 32'(r_to), 32'd0);
        chk({tag, " hit"}, 32'(r_hit0), 32'(v.hit0));
        chk({tag, " ready_cnt"}, r_ready_cnt, v.rdy);
        chk({tag, " beats"}, r_beats, v.beats);
        chk({tag, " rom_addr_bad"}, 32'(r_addr_bad), 32'd0);
        if (v.rdy > 0) begin
            chk({tag, " inst"}, r_inst, v.inst);
            chk({tag, " latency"}, r_lat, v.lat);
        end
        if (v.rsa >= 0) chk({tag, " zero_after_rst"}, 32'(r_zero_ok), 32'd1);
        idx = int'(v.addr[7:4]);
        if (v.rsa >= 0) begin
            for (int i = 0; i < 16; i++) mv[i] = 0;
        end else if (!v.hit0 && v.jmp != 0) begin
            mv[idx] = 1;
            mt[idx] = v.addr[31:8];
        end
    endtask

    vec_t vt [10];

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hC0DE_0000 | 32'(i << 2);
        rom_mem[0] = 32'h11; rom_mem[1] = 32'h22;
        rom_mem[2] = 32'h33; rom_mem[3] = 32'h44;
        for (int i = 0; i < 16; i++) begin mv[i] = 0; mt[i] = '0; end

        vt[0] = '{32'h08,  1, -1, -1, 0, 1, 10, 32'h33, 4};
        vt[1] = '{32'h0C,  0, -1, -1, 1, 1, 1,  32'h44, 0};
        vt[2] = '{32'h00,  0, -1, -1, 1, 1, 1,  32'h11, 0};
        vt[3] = '{32'h100, 0, -1, -1, 0, 1, 6,  32'hC0DE_0100, 4};
        vt[4] = '{32'h00,  0, -1, -1, 0, 1, 6,  32'h11, 4};
        vt[5] = '{32'h40,  0,  2, -1, 0, 0, 0,  32'h0, 4};
        vt[6] = '{32'h44,  0, -1, -1, 1, 1, 1,  32'hC0DE_0044, 0};
        vt[7] = '{32'h80,  0, -1,  2, 0, 0, 0,  32'h0, 2};
        vt[8] = '{32'h80,  2, -1, -1, 0, 1, 14, 32'hC0DE_0080, 4};
        vt[9] = '{32'h8C,  0, -1, -1, 1, 1, 1,  32'hC0DE_008C, 0};

        rst = 1'b1;
        bus.if_req_Icache_i  = 1'b1;
        bus.if_addr_i        = 32'h08;
        bus.if_jump_Icache_i = 1'b0;
        bus.rom_ready_i      = 1'b0;
        bus.rom_data_i       = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset outputs",
            {bus.Icache_hit_o, bus.Icache_ready_o, bus.Icache_req_rom_o,
             |bus.Icache_inst_o, |bus.Icache_addr_rom_o}, 32'd0);
        rst = 1'b0;
        bus.if_req_Icache_i = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Stray ROM beats while idle must not touch the arrays
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.if_req_Icache_i = 1'b0;
            bus.rom_ready_i     = 1'b1;
            bus.rom_data_i      = 32'hDEAD;
            #1;
            chk("stray idle outputs",
                {bus.Icache_ready_o, bus.Icache_req_rom_o}, 32'd0);
        end
        @(negedge clk);
        bus.rom_ready_i = 1'b0;
        bus.rom_data_i  = '0;
        run_vec('{32'h84, 0, -1, -1, 1, 1, 1, 32'hC0DE_0084, 0}, "stray_hit");

        for (int n = 0; n < 200; n++) begin
            vec_t v;
            logic [31:0] a;
            bit eh;
            int g;
            int j;
            int r;
            a  = 32'($urandom_range(0, 255)) << 2;
            eh = mv[a[7:4]] && (mt[a[7:4]] == a[31:8]);
            g  = int'($urandom_range(0, 2));
            j  = -1;
            r  = -1;
            if (!eh) begin
                if ($urandom_range(0, 9) == 0) j = int'($urandom_range(1, 4));
                else if ($urandom_range(0, 19) == 0) r = int'($urandom_range(1, 3));
            end
            v.addr  = a;
            v.gap   = g;
            v.jmp   = j;
            v.rsa   = r;
            v.hit0  = eh;
            v.rdy   = (eh || (j < 0 && r < 0)) ? 1 : 0;
            v.lat   = eh ? 1 : 6 + 4 * g;
            v.inst  = rom_mem[a[11:2]];
            v.beats = eh ? 0 : (r >= 0 ? r : 4);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
